traffic_fsm_controller: RTL and testbench



---
 rtl/traffic_pkg.sv | 50 +++++
 rtl/traffic_fsm_controller_clearance_timer.sv | 27 ++
 rtl/traffic_fsm_controller.sv | 107 ++++++++++
 tb/tb_traffic_fsm_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light controller and data path:
// light commands, time-select values, state codes and per-state decode helpers.
package traffic_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  localparam logic TIME_SEL_GREEN  = 1'b1;
  localparam logic TIME_SEL_YELLOW = 1'b0;

  // Codes 6 and 7 are unused and recover to ALL_RED_TO_NS.
  typedef enum logic [2:0] {
    NS_GREEN      = 3'd0,
    NS_YELLOW     = 3'd1,
    ALL_RED_TO_EW = 3'd2,
    EW_GREEN      = 3'd3,
    EW_YELLOW     = 3'd4,
    ALL_RED_TO_NS = 3'd5
  } state_t;

  function automatic logic is_green(input state_t s);
    return (s == NS_GREEN) || (s == EW_GREEN);
  endfunction

  function automatic logic is_yellow(input state_t s);
    return (s == NS_YELLOW) || (s == EW_YELLOW);
  endfunction

  function automatic logic is_all_red(input state_t s);
    return (s == ALL_RED_TO_EW) || (s == ALL_RED_TO_NS);
  endfunction

  function automatic logic [1:0] ns_cmd(input state_t s);
    case (s)
      NS_GREEN:  return LIGHT_GREEN;
      NS_YELLOW: return LIGHT_YELLOW;
      default:   return LIGHT_RED;
    endcase
  endfunction

  function automatic logic [1:0] ew_cmd(input state_t s);
    case (s)
      EW_GREEN:  return LIGHT_GREEN;
      EW_YELLOW: return LIGHT_YELLOW;
      default:   return LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_fsm_controller_clearance_timer.sv
// All-red clearance down counter: reloads to ALL_RED_CYCLES-1, counts down to
// zero and holds there; done is high while the count reads zero.
module clearance_timer #(
  parameter int ALL_RED_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int CNT_W = (ALL_RED_CYCLES < 1) ? 1 : $clog2(ALL_RED_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(ALL_RED_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/traffic_fsm_controller.sv
// Traffic-light control FSM: sequences NS/EW green, yellow and all-red phases.
// Optional pedestrian early-yellow request is enabled by defining PED_REQ_EN.
module traffic_fsm_controller
  import traffic_pkg::*;
#(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int ALL_RED_SECONDS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       timer_zero,
`ifdef PED_REQ_EN
  input  logic       ped_req,
`endif
  output logic       load_enable,
  output logic       time_sel,
  output logic [1:0] ns_light_cmd,
  output logic [1:0] ew_light_cmd,
  output logic [2:0] phase
);

  localparam int ALL_RED_CYCLES = CLK_FREQ * ALL_RED_SECONDS;

  state_t state;
  state_t next_state;
  logic   entering;
  logic   armed;
  logic   arm_pend;
  logic   clr_load;
  logic   clr_done;
  logic   ped_pending;
  logic   ped_go;

  clearance_timer #(
    .ALL_RED_CYCLES(ALL_RED_CYCLES)
  ) u_clearance (
    .clk  (clk),
    .reset(reset),
    .load (clr_load),
    .done (clr_done)
  );

`ifdef PED_REQ_EN
  // A request raised in the last armed green cycle acts immediately.
  assign ped_go = ped_pending | ped_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      ped_pending <= 1'b0;
    end else if (entering && is_yellow(next_state)) begin
      ped_pending <= 1'b0;
    end else begin
      ped_pending <= ped_pending | ped_req;
    end
  end
`else
  assign ped_pending = 1'b0;
  assign ped_go      = ped_pending;
`endif

  always_comb begin
    next_state = state;
    case (state)
      NS_GREEN:      if (armed && (timer_zero || ped_go)) next_state = NS_YELLOW;
      NS_YELLOW:     if (armed && timer_zero)             next_state = ALL_RED_TO_EW;
      ALL_RED_TO_EW: if (clr_done)                        next_state = EW_GREEN;
      EW_GREEN:      if (armed && (timer_zero || ped_go)) next_state = EW_YELLOW;
      EW_YELLOW:     if (armed && timer_zero)             next_state = ALL_RED_TO_NS;
      ALL_RED_TO_NS: if (clr_done)                        next_state = NS_GREEN;
      default:                                            next_state = ALL_RED_TO_NS;
    endcase
  end

  assign entering = (next_state != state);
  assign clr_load = entering && is_all_red(next_state);

  // Outputs are decoded from next_state so they change together with state.
  // armed rises on the third cycle of a state: timer_zero is stale until the
  // data-path counter has actually reloaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ALL_RED_TO_NS;
      load_enable  <= 1'b0;
      time_sel     <= TIME_SEL_YELLOW;
      ns_light_cmd <= LIGHT_RED;
      ew_light_cmd <= LIGHT_RED;
      phase        <= ALL_RED_TO_NS;
      armed        <= 1'b0;
      arm_pend     <= 1'b0;
    end else begin
      state        <= next_state;
      load_enable  <= entering && (is_green(next_state) || is_yellow(next_state));
      time_sel     <= is_green(next_state) ? TIME_SEL_GREEN : TIME_SEL_YELLOW;
      ns_light_cmd <= ns_cmd(next_state);
      ew_light_cmd <= ew_cmd(next_state);
      phase        <= next_state;
      if (entering) begin
        armed    <= 1'b0;
        arm_pend <= 1'b0;
      end else begin
        arm_pend <= 1'b1;
        armed    <= arm_pend;
      end
    end
  end

endmodule

// File: tb/tb_traffic_fsm_controller.sv
// Scoreboard bench for traffic_fsm_controller with a behavioural phase model
// and a model of the data-path down counter (green 30, yellow 5 ticks).
module tb_traffic_fsm_controller;
  import traffic_pkg::*;

  localparam int N = 10;
`ifdef PED_REQ_EN
  localparam bit PED_ON = 1'b1;
`else
  localparam bit PED_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       timer_zero = 1'b0;
`ifdef PED_REQ_EN
  logic       ped_req = 1'b0;
`endif
  logic       load_enable;
  logic       time_sel;
  logic [1:0] ns_light_cmd;
  logic [1:0] ew_light_cmd;
  logic [2:0] phase;

  always #5 clk = ~clk;

  traffic_fsm_controller #(
    .CLK_FREQ(10),
    .ALL_RED_SECONDS(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .timer_zero  (timer_zero),
`ifdef PED_REQ_EN
    .ped_req     (ped_req),
`endif
    .load_enable (load_enable),
    .time_sel    (time_sel),
    .ns_light_cmd(ns_light_cmd),
    .ew_light_cmd(ew_light_cmd),
    .phase       (phase)
  );

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];

  int m_phase = 5;
  int m_age = 1;
  bit m_pend = 1'b0;
  int dp_cnt = 0;
  bit tz_force = 1'b0;
  bit ped = 1'b0;
  int cur_phase = 5;
  int load_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] pack_exp(input int p, input int age);
    logic [1:0] ns;
    logic [1:0] ew;
    logic timed;
    ns = (p == 0) ? 2'b10 : (p == 1) ? 2'b01 : 2'b00;
    ew = (p == 3) ? 2'b10 : (p == 4) ? 2'b01 : 2'b00;
    timed = (p == 0) || (p == 1) || (p == 3) || (p == 4);
    return {3'(p), ns, ew, (age == 1) && timed, (p == 0) || (p == 3)};
  endfunction

  task automatic model_step(input bit r, input bit tz, input bit pd);
    bit go;
    if (r) begin
      m_phase = 5; m_age = 1; m_pend = 1'b0;
    end else begin
      case (m_phase)
        0, 1, 3, 4: begin
          go = tz || (PED_ON && (m_pend || pd) && (m_phase == 0 || m_phase == 3));
          if (m_age >= 3 && go) begin
            m_phase = (m_phase + 1) % 6;
            m_age = 1;
          end else begin
            m_age++;
          end
        end
        2, 5: begin
          if (m_age >= N) begin
            m_phase = (m_phase + 1) % 6;
            m_age = 1;
          end else begin
            m_age++;
          end
        end
        default: begin
          m_phase = 5; m_age = 1;
        end
      endcase
      if (m_age == 1 && (m_phase == 1 || m_phase == 4)) m_pend = 1'b0;
      else m_pend = m_pend | (PED_ON && pd);
    end
  endtask

  task automatic tick(input logic rst_in);
    logic le;
    logic ts;
    logic [8:0] e;
    logic [8:0] act;
    reset = rst_in;
    timer_zero = tz_force ? 1'b1 : (dp_cnt == 0);
`ifdef PED_REQ_EN
    ped_req = ped;
`endif
    model_step(rst_in, timer_zero, ped);
    exp_q.push_back(pack_exp(m_phase, m_age));
    le = load_enable;
    ts = time_sel;
    @(posedge clk);
    #1;
    if (le === 1'b1) dp_cnt = (ts === 1'b1) ? 30 : 5;
    else if (dp_cnt > 0) dp_cnt--;
    e = exp_q.pop_front();
    act = {phase, ns_light_cmd, ew_light_cmd, load_enable, time_sel};
    chk("scoreboard", 32'(act), 32'(e));
    chk("both_nonred", 32'(ns_light_cmd != 2'b00 && ew_light_cmd != 2'b00), 0);
    if (int'(phase) != cur_phase) begin
      if (cur_phase == 0 || cur_phase == 1 || cur_phase == 3 || cur_phase == 4)
        chk("one_load_per_state", load_cnt, 1);
      cur_phase = int'(phase);
      load_cnt = 0;
    end
    if (load_enable === 1'b1) load_cnt++;
  endtask

  task automatic run_until(input int p, input int budget, input string tag, output int n);
    n = 0;
    while (int'(phase) != p && n < budget) begin
      tick(1'b0);
      n++;
    end
    if (int'(phase) != p) chk(tag, 32'(phase), 32'(p));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seq[$];
    int exp_seq[7];
    exp_seq = '{0, 1, 2, 3, 4, 5, 0};

    repeat (3) tick(1'b1);
    chk("rst_phase", 32'(phase), 5);
    chk("rst_cmds", 32'({ns_light_cmd, ew_light_cmd}), 0);
    chk("rst_load", 32'(load_enable), 0);
    chk("rst_sel", 32'(time_sel), 0);

    // Stale timer_zero held high from before the first green load.
    tz_force = 1'b1;
    run_until(0, 20, "first_green_timeout", n);
    chk("first_green_delay", n, N);
    chk("green_load", 32'(load_enable), 1);
    chk("green_sel", 32'(time_sel), 1);
    chk("green_ns", 32'(ns_light_cmd), 2);
    chk("green_ew", 32'(ew_light_cmd), 0);
    tick(1'b0);
    chk("no_exit_c2", 32'(phase), 0);
    chk("load_one_cycle", 32'(load_enable), 0);
    tick(1'b0);
    chk("no_exit_c3", 32'(phase), 0);
    tick(1'b0);
    chk("exit_to_yellow", 32'(phase), 1);
    chk("yellow_load", 32'(load_enable), 1);
    chk("yellow_sel", 32'(time_sel), 0);
    chk("yellow_ns", 32'(ns_light_cmd), 1);
    tz_force = 1'b0;

    // Full cycle driven by the data-path counter model.
    run_until(0, 300, "cycle_start_timeout", n);
    seq.push_back(0);
    n = 0;
    while (seq.size() < 7 && n < 400) begin
      tick(1'b0);
      n++;
      if (int'(phase) != seq[seq.size()-1]) seq.push_back(int'(phase));
    end
    chk("seq_len", seq.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < seq.size()) chk("phase_seq", seq[i], exp_seq[i]);
    end

    // Reset during EW_YELLOW.
    run_until(4, 300, "ew_yellow_timeout", n);
    tick(1'b0);
    tick(1'b1);
    chk("midrst_cmds", 32'({ns_light_cmd, ew_light_cmd}), 0);
    chk("midrst_load", 32'(load_enable), 0);
    chk("midrst_phase", 32'(phase), 5);
    run_until(0, 30, "post_rst_green_timeout", n);
    chk("post_rst_green_delay", n, N);

    // Pedestrian request at cycle 5 of EW_GREEN.
    run_until(3, 300, "ew_green_timeout", n);
    repeat (4) tick(1'b0);
    ped = 1'b1;
    tick(1'b0);
    ped = 1'b0;
`ifdef PED_REQ_EN
    chk("ped_early_yellow", 32'(phase), 4);
    chk("ped_load", 32'(load_enable), 1);
    chk("ped_pending_clr", 32'(dut.ped_pending), 0);
`else
    chk("ped_ignored", 32'(phase), 3);
    tick(1'b0);
    chk("ped_ignored_c7", 32'(phase), 3);
`endif

    // Backdoor illegal state code.
    force dut.state = state_t'(3'd7);
    m_phase = 7;
    tick(1'b0);
    chk("illegal_phase", 32'(phase), 5);
    chk("illegal_cmds", 32'({ns_light_cmd, ew_light_cmd}), 0);
    chk("illegal_load", 32'(load_enable), 0);
    release dut.state;
    tick(1'b1);
    tick(1'b1);
    run_until(0, 30, "resync_green_timeout", n);
    chk("resync_green_delay", n, N);

    chk("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
